uart_receiver: RTL and testbench

//  - Serial-to-parallel stage directly downstream of the UART sender: recovers frames from line rxd.
//  - Presents each byte on a 4-phase req/ack handshake (receiver drives req, consumer drives ack).
//  - Flags framing errors and overruns.

---
 rtl/uart_pkg.sv | 27 ++
 rtl/uart_tick_gen.sv | 37 +++
 rtl/uart_receiver.sv | 180 ++++++++++++++++++
 tb/tb_uart_receiver.sv | 424 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: state encodings, frame constants and defaults for the UART
// receive path.
package uart_pkg;

   localparam int unsigned CLKS_PER_TICK_DEF = 580;
   localparam int unsigned TICKS_PER_BIT_DEF = 9;
   localparam int unsigned FRAME_DATA_BITS   = 8;

   typedef enum logic [1:0] {
      RX_IDLE,
      RX_START,
      RX_DATA,
      RX_STOP
   } rx_state_e;

   typedef enum logic [1:0] {
      HS_IDLE,
      HS_REQ,
      HS_DONE
   } hs_state_e;

   // The sender shifts d[1]..d[7] first and d[0] last.
   function automatic logic [2:0] bit_idx(input logic [2:0] k);
      return k + 3'd1;
   endfunction

endpackage

// File: rtl/uart_tick_gen.sv
// uart_tick_gen: free-running oversample divider with synchronous restart.
// Shared with the sender so both ends count ticks identically.
module uart_tick_gen #(
   parameter int unsigned CLKS_PER_TICK = 580
) (
   input  logic clk,
   input  logic clr,
   input  logic restart_i,
   output logic tick_o
);

   localparam int unsigned W =
      (CLKS_PER_TICK > 1) ? $clog2(CLKS_PER_TICK) : 1;
   localparam logic [W-1:0] LAST = W'(CLKS_PER_TICK - 1);

   logic [W-1:0] div_q;
   logic [W-1:0] div_d;

   always_comb begin
      if (restart_i || div_q == LAST) begin
         div_d = '0;
      end else begin
         div_d = div_q + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         div_q <= '0;
      end else begin
         div_q <= div_d;
      end
   end

   assign tick_o = (div_q == LAST) && !restart_i;

endmodule

// File: rtl/uart_receiver.sv
// uart_receiver: frame recovery from rxd with a 4-phase req/ack output.
// Define UART_RX_MAJORITY_EN for 2-of-3 majority sampling around mid-bit.
module uart_receiver
   import uart_pkg::*;
#(
   parameter int unsigned CLKS_PER_TICK = CLKS_PER_TICK_DEF,
   parameter int unsigned TICKS_PER_BIT = TICKS_PER_BIT_DEF
) (
   input  logic                       clk,
   input  logic                       clr,
   input  logic                       rxd,
   input  logic                       ack,
   output logic [FRAME_DATA_BITS-1:0] data,
   output logic                       req,
   output logic                       frm_err,
   output logic                       ovr
);

   localparam int unsigned TW =
      (TICKS_PER_BIT > 1) ? $clog2(TICKS_PER_BIT) : 1;
   localparam int unsigned MID = TICKS_PER_BIT / 2;
   localparam logic [TW-1:0] LAST_T = TW'(TICKS_PER_BIT - 1);
`ifdef UART_RX_MAJORITY_EN
   localparam logic [TW-1:0] PRE_T = TW'(MID - 1);
   localparam logic [TW-1:0] MID_T = TW'(MID);
   localparam logic [TW-1:0] SMP_T = TW'(MID + 1);
`else
   localparam logic [TW-1:0] SMP_T = TW'(MID);
`endif
   localparam logic [2:0] LAST_BIT = 3'(FRAME_DATA_BITS - 1);

   logic [1:0] sync_q;
   logic       rxs;
   logic       rxs_prev_q;
   logic       fall;
   logic       tick;
   logic       restart;
   logic       smp_now;
   logic       smp_bit;
   logic       bit_end;
   logic       load;
   logic       hs_busy;

   rx_state_e  rx_q;
   hs_state_e  hs_q;
   logic [TW-1:0] tix_q;
   logic [2:0]    bit_q;
   logic [FRAME_DATA_BITS-1:0] shf_q;
   logic [FRAME_DATA_BITS-1:0] data_q;
   logic req_q;
   logic frm_q;
   logic ovr_q;
`ifdef UART_RX_MAJORITY_EN
   logic [1:0] maj_q;
`endif

   assign rxs     = sync_q[1];
   assign fall    = rxs_prev_q && !rxs;
   assign restart = (rx_q == RX_IDLE) && fall;
   assign smp_now = tick && (tix_q == SMP_T);
   assign bit_end = tick && (tix_q == LAST_T);
   assign hs_busy = (hs_q != HS_IDLE);

`ifdef UART_RX_MAJORITY_EN
   assign smp_bit = (maj_q[0] & maj_q[1]) |
                    (maj_q[0] & rxs) |
                    (maj_q[1] & rxs);
`else
   assign smp_bit = rxs;
`endif

   assign load = smp_now && (rx_q == RX_STOP) &&
                 smp_bit && !hs_busy;

   uart_tick_gen #(
      .CLKS_PER_TICK(CLKS_PER_TICK)
   ) u_tick (
      .clk      (clk),
      .clr      (clr),
      .restart_i(restart),
      .tick_o   (tick)
   );

   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         sync_q     <= 2'b11;
         rxs_prev_q <= 1'b1;
         rx_q       <= RX_IDLE;
         tix_q      <= '0;
         bit_q      <= '0;
         shf_q      <= '0;
         frm_q      <= 1'b0;
         ovr_q      <= 1'b0;
`ifdef UART_RX_MAJORITY_EN
         maj_q      <= 2'b11;
`endif
      end else begin
         sync_q     <= {sync_q[0], rxd};
         rxs_prev_q <= rxs;
         frm_q      <= 1'b0;
         ovr_q      <= 1'b0;
         if (tick && rx_q != RX_IDLE) begin
            tix_q <= bit_end ? '0 : tix_q + 1'b1;
         end
`ifdef UART_RX_MAJORITY_EN
         if (tick && tix_q == PRE_T) maj_q[0] <= rxs;
         if (tick && tix_q == MID_T) maj_q[1] <= rxs;
`endif
         unique case (rx_q)
            RX_IDLE: begin
               if (fall) begin
                  rx_q  <= RX_START;
                  tix_q <= '0;
               end
            end
            RX_START: begin
               if (smp_now && smp_bit) begin
                  rx_q <= RX_IDLE;
               end else if (bit_end) begin
                  rx_q  <= RX_DATA;
                  bit_q <= '0;
               end
            end
            RX_DATA: begin
               if (smp_now) shf_q[bit_idx(bit_q)] <= smp_bit;
               if (bit_end) begin
                  if (bit_q == LAST_BIT) rx_q <= RX_STOP;
                  else bit_q <= bit_q + 1'b1;
               end
            end
            RX_STOP: begin
               // stop2 is left unchecked so the next start can follow.
               if (smp_now) begin
                  rx_q <= RX_IDLE;
                  if (!smp_bit) frm_q <= 1'b1;
                  else if (hs_busy) ovr_q <= 1'b1;
               end
            end
            default: rx_q <= RX_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         hs_q   <= HS_IDLE;
         data_q <= '0;
         req_q  <= 1'b0;
      end else begin
         unique case (hs_q)
            HS_IDLE: begin
               if (load) begin
                  data_q <= shf_q;
                  req_q  <= 1'b1;
                  hs_q   <= HS_REQ;
               end
            end
            HS_REQ: begin
               if (ack) begin
                  req_q <= 1'b0;
                  hs_q  <= HS_DONE;
               end
            end
            HS_DONE: begin
               if (!ack) hs_q <= HS_IDLE;
            end
            default: begin
               req_q <= 1'b0;
               hs_q  <= HS_IDLE;
            end
         endcase
      end
   end

   assign data    = data_q;
   assign req     = req_q;
   assign frm_err = frm_q;
   assign ovr     = ovr_q;

endmodule

// File: tb/tb_uart_receiver.sv
// tb_uart_receiver: scenario tasks against a frame-level line model.
module tb_uart_receiver;

   localparam int CPT  = 2;
   localparam int TPB  = 9;
   localparam int BITC = CPT * TPB;

   logic       clk = 1'b0;
   logic       clr = 1'b1;
   logic       rxd = 1'b1;
   logic       ack;
   logic       ack_man  = 1'b0;
   logic       ack_auto = 1'b0;
   logic       auto_ack = 1'b0;
   logic [7:0] data;
   logic       req;
   logic       frm_err;
   logic       ovr;

   int errors = 0;
   int checks = 0;

   logic [7:0] got[$];
   int frm_cnt   = 0;
   int ovr_cnt   = 0;
   int width_err = 0;
   int stab_err  = 0;
   logic       req_p  = 1'b0;
   logic       frm_p  = 1'b0;
   logic       ovr_p  = 1'b0;
   logic [7:0] data_p = 8'h00;

   assign ack = auto_ack ? ack_auto : ack_man;

   uart_receiver #(
      .CLKS_PER_TICK(CPT),
      .TICKS_PER_BIT(TPB)
   ) dut (
      .clk    (clk),
      .clr    (clr),
      .rxd    (rxd),
      .ack    (ack),
      .data   (data),
      .req    (req),
      .frm_err(frm_err),
      .ovr    (ovr)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (clr) begin
         req_p = 1'b0;
         frm_p = 1'b0;
         ovr_p = 1'b0;
      end else begin
         if (req && !req_p) got.push_back(data);
         if (req && req_p && data !== data_p) stab_err++;
         if (frm_err && !frm_p) frm_cnt++;
         if (ovr && !ovr_p) ovr_cnt++;
         if ((frm_err && frm_p) || (ovr && ovr_p)) width_err++;
         req_p  = req;
         frm_p  = frm_err;
         ovr_p  = ovr;
         data_p = data;
      end
   end

   initial begin
      forever begin
         @(negedge clk);
         ack_auto = req;
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic logic [10:0] frame(input logic [7:0] b,
                                         input logic s1);
      logic [10:0] f;
      f[0] = 1'b0;
      for (int k = 1; k < 8; k++) f[k] = b[k];
      f[8]  = b[0];
      f[9]  = s1;
      f[10] = 1'b1;
      return f;
   endfunction

   task automatic send_bits(input logic [10:0] f, input int n);
      for (int i = 0; i < n; i++) begin
         rxd = f[i];
         repeat (BITC) @(posedge clk);
      end
   endtask

   task automatic send(input logic [7:0] b, input logic s1);
      send_bits(frame(b, s1), 11);
   endtask

   task automatic wait_req(input logic lvl, input int maxc,
                           output bit ok);
      ok = 1'b0;
      for (int i = 0; i < maxc; i++) begin
         @(negedge clk);
         if (req === lvl) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic test_reset();
      clr = 1'b1;
      repeat (3) @(negedge clk);
      checks++;
      if (data !== 8'h00) begin
         errors++;
         $display("FAIL reset_data got=%h exp=00", data);
      end
      checks++;
      if (req !== 1'b0) begin
         errors++;
         $display("FAIL reset_req got=%b exp=0", req);
      end
      checks++;
      if (frm_err !== 1'b0) begin
         errors++;
         $display("FAIL reset_frm got=%b exp=0", frm_err);
      end
      checks++;
      if (ovr !== 1'b0) begin
         errors++;
         $display("FAIL reset_ovr got=%b exp=0", ovr);
      end
      clr = 1'b0;
      repeat (5) @(negedge clk);
   endtask

   task automatic test_basic();
      bit ok;
      auto_ack = 1'b0;
      got.delete();
      send(8'hA5, 1'b1);
      @(negedge clk);
      checks++;
      if (got.size() !== 1 || got[0] !== 8'hA5) begin
         errors++;
         $display("FAIL basic_byte n=%0d got=%h exp=a5",
                  got.size(), (got.size() > 0) ? got[0] : 8'hxx);
      end
      checks++;
      if (req !== 1'b1 || data !== 8'hA5) begin
         errors++;
         $display("FAIL basic_hold req=%b data=%h exp req=1 data=a5",
                  req, data);
      end
      ack_man = 1'b1;
      wait_req(1'b0, 10, ok);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL basic_ack req=%b exp=0 after ack", req);
      end
      ack_man = 1'b0;
      repeat (4) @(negedge clk);
   endtask

   task automatic test_random();
      logic [7:0] exp[$];
      logic [7:0] b;
      int ovr0;
      int frm0;
      ovr0 = ovr_cnt;
      frm0 = frm_cnt;
      got.delete();
      auto_ack = 1'b1;
      repeat (6) begin
         b = 8'($urandom);
         exp.push_back(b);
         send(b, 1'b1);
      end
      repeat (10) @(negedge clk);
      checks++;
      if (got.size() !== exp.size()) begin
         errors++;
         $display("FAIL rand_count got=%0d exp=%0d",
                  got.size(), exp.size());
      end
      for (int i = 0; i < exp.size() && i < got.size(); i++) begin
         checks++;
         if (got[i] !== exp[i]) begin
            errors++;
            $display("FAIL rand_byte%0d got=%h exp=%h",
                     i, got[i], exp[i]);
         end
      end
      checks++;
      if (ovr_cnt != ovr0 || frm_cnt != frm0) begin
         errors++;
         $display("FAIL rand_flags ovr=%0d frm=%0d exp=0 0",
                  ovr_cnt - ovr0, frm_cnt - frm0);
      end
      auto_ack = 1'b0;
   endtask

   task automatic test_back_to_back();
      bit ok;
      int ovr0;
      ovr0 = ovr_cnt;
      got.delete();
      send(8'h00, 1'b1);
      send(8'hFF, 1'b1);
      @(negedge clk);
      checks++;
      if (got.size() !== 1 || data !== 8'h00 || req !== 1'b1) begin
         errors++;
         $display("FAIL b2b_hold n=%0d data=%h req=%b exp 1 00 1",
                  got.size(), data, req);
      end
      checks++;
      if (ovr_cnt - ovr0 != 1) begin
         errors++;
         $display("FAIL b2b_ovr got=%0d exp=1", ovr_cnt - ovr0);
      end
      ack_man = 1'b1;
      wait_req(1'b0, 10, ok);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL b2b_ack req=%b exp=0", req);
      end
      ack_man = 1'b0;
      repeat (4) @(negedge clk);
   endtask

   task automatic test_frame_err();
      int frm0;
      frm0 = frm_cnt;
      got.delete();
      auto_ack = 1'b1;
      send(8'h3C, 1'b0);
      @(negedge clk);
      checks++;
      if (frm_cnt - frm0 != 1) begin
         errors++;
         $display("FAIL ferr_pulse got=%0d exp=1", frm_cnt - frm0);
      end
      checks++;
      if (got.size() != 0 || req !== 1'b0) begin
         errors++;
         $display("FAIL ferr_req n=%0d req=%b exp 0 0",
                  got.size(), req);
      end
      send(8'h3C, 1'b1);
      repeat (4) @(negedge clk);
      checks++;
      if (got.size() !== 1 || got[0] !== 8'h3C) begin
         errors++;
         $display("FAIL ferr_next n=%0d exp 1 byte 3c", got.size());
      end
      auto_ack = 1'b0;
   endtask

   task automatic test_false_start();
      int frm0;
      frm0 = frm_cnt;
      got.delete();
      auto_ack = 1'b1;
      rxd = 1'b0;
      repeat (3 * CPT) @(posedge clk);
      rxd = 1'b1;
      repeat (11 * BITC) @(posedge clk);
      checks++;
      if (got.size() != 0 || frm_cnt != frm0) begin
         errors++;
         $display("FAIL fstart_quiet n=%0d frm=%0d exp 0 0",
                  got.size(), frm_cnt - frm0);
      end
      send(8'h81, 1'b1);
      repeat (4) @(negedge clk);
      checks++;
      if (got.size() !== 1 || got[0] !== 8'h81) begin
         errors++;
         $display("FAIL fstart_next n=%0d exp 1 byte 81", got.size());
      end
      auto_ack = 1'b0;
   endtask

   task automatic test_reset_mid();
      logic [10:0] f;
      f = frame(8'h12, 1'b1);
      auto_ack = 1'b0;
      send_bits(f, 4);
      rxd = f[4];
      repeat (BITC / 2) @(posedge clk);
      clr = 1'b1;
      rxd = 1'b1;
      #1;
      checks++;
      if (data !== 8'h00 || req !== 1'b0 ||
          frm_err !== 1'b0 || ovr !== 1'b0) begin
         errors++;
         $display("FAIL rstmid_out data=%h req=%b frm=%b ovr=%b exp 0",
                  data, req, frm_err, ovr);
      end
      repeat (3) @(negedge clk);
      clr = 1'b0;
      got.delete();
      repeat (4) @(negedge clk);
      send(8'h5A, 1'b1);
      @(negedge clk);
      checks++;
      if (got.size() !== 1 || got[0] !== 8'h5A || req !== 1'b1) begin
         errors++;
         $display("FAIL rstmid_next n=%0d req=%b exp 1 byte 5a",
                  got.size(), req);
      end
      clr = 1'b1;
      #1;
      checks++;
      if (data !== 8'h00 || req !== 1'b0) begin
         errors++;
         $display("FAIL rsths_out data=%h req=%b exp 00 0", data, req);
      end
      repeat (3) @(negedge clk);
      clr = 1'b0;
      got.delete();
      auto_ack = 1'b1;
      repeat (4) @(negedge clk);
      send(8'h5A, 1'b1);
      repeat (4) @(negedge clk);
      checks++;
      if (got.size() !== 1 || got[0] !== 8'h5A) begin
         errors++;
         $display("FAIL rsths_next n=%0d exp 1 byte 5a", got.size());
      end
      auto_ack = 1'b0;
   endtask

   task automatic test_loopback();
      logic [7:0] exp[4];
      exp[0] = 8'h00;
      exp[1] = 8'h55;
      exp[2] = 8'hAA;
      exp[3] = 8'hFF;
      got.delete();
      auto_ack = 1'b1;
      for (int i = 0; i < 4; i++) send(exp[i], 1'b1);
      repeat (4) @(negedge clk);
      checks++;
      if (got.size() !== 4) begin
         errors++;
         $display("FAIL loop_count got=%0d exp=4", got.size());
      end
      for (int i = 0; i < 4 && i < got.size(); i++) begin
         checks++;
         if (got[i] !== exp[i]) begin
            errors++;
            $display("FAIL loop_byte%0d got=%h exp=%h",
                     i, got[i], exp[i]);
         end
      end
      auto_ack = 1'b0;
   endtask

`ifdef UART_RX_MAJORITY_EN
   task automatic test_glitch();
      logic [10:0] f;
      f = frame(8'h0F, 1'b1);
      got.delete();
      auto_ack = 1'b1;
      for (int i = 0; i < 11; i++) begin
         rxd = f[i];
         if (i == 3) begin
            repeat (BITC / 2 - 1) @(posedge clk);
            rxd = ~f[i];
            repeat (CPT) @(posedge clk);
            rxd = f[i];
            repeat (BITC - BITC / 2 + 1 - CPT) @(posedge clk);
         end else begin
            repeat (BITC) @(posedge clk);
         end
      end
      repeat (4) @(negedge clk);
      checks++;
      if (got.size() !== 1 || got[0] !== 8'h0F) begin
         errors++;
         $display("FAIL glitch_byte n=%0d exp 1 byte 0f", got.size());
      end
      auto_ack = 1'b0;
   endtask
`endif

   initial begin
      test_reset();
      test_basic();
      test_random();
      test_back_to_back();
      test_frame_err();
      test_false_start();
      test_reset_mid();
      test_loopback();
`ifdef UART_RX_MAJORITY_EN
      test_glitch();
`endif
      checks++;
      if (width_err != 0) begin
         errors++;
         $display("FAIL pulse_width got=%0d long pulses exp=0", width_err);
      end
      checks++;
      if (stab_err != 0) begin
         errors++;
         $display("FAIL data_stable got=%0d changes exp=0", stab_err);
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
